block_serializer: RTL and testbench
===================================

# block_serializer

Downstream consumer of the 128-bit plaintext FIFO in the verification data generator. Pops one 128-bit block at a time and streams it to the AES chip stimulus interface as 16 bytes over a valid/ready byte channel, most significant byte first. Marks the first byte of each block and pulses a completion strobe after the last byte is accepted.

## Interface
- `BYTES`, 16: bytes per block; fixed at 16 for AES-128, and the counter width is 4 bits.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  permission to start a new block; an in-progress block always completes.
- `fifo_data`  input  128  FIFO read data; valid in the cycle after `fifo_pop`.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_pop`  output  1  single-cycle FIFO read request.
- `byte_out`  output  8  current byte.
- `byte_valid`  output  1  `byte_out` is valid.
- `byte_ready`  input  1  sink accepts the byte when `byte_valid && byte_ready`.
- `byte_first`  output  1  high with byte 0 of each block.
- `block_done`  output  1  one-cycle pulse after byte 15 is accepted.
- `byte_par`  output  1  odd parity of `byte_out`; present only with `BLOCK_SER_PARITY_EN` (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE: if `en && !fifo_empty`, assert `fifo_pop` for this cycle and go to WAIT.
  - WAIT: latch `fifo_data` into the 128-bit shift register, clear the byte counter, go to SEND.
  - SEND: `byte_valid` = 1 and `byte_out` = shreg[127:120]. On handshake: shift the register left by 8 and increment the counter. On the handshake with counter = 15: go to DONE.
  - DONE: `block_done` = 1 for one cycle, then go to IDLE.
- Byte order: byte k = `fifo_data[127-8k -: 8]`.
- `byte_first` = (state == SEND) && (counter == 0).
- While `byte_ready` is low, `byte_out` holds stable; valid is never withdrawn.
- `fifo_pop` is asserted only in IDLE with `!fifo_empty`. The block never pops an empty FIFO and never pops twice per block.
- Deasserting `en` mid-block does not stop the block; it only blocks the next IDLE→WAIT transition.
- Any `rst_n` low, including mid-block, aborts immediately. The partial block is discarded and not resumed.

## Timing
- Reset values: `fifo_pop`=0, `byte_valid`=0, `byte_out`=8'h00, `byte_first`=0, `block_done`=0, `byte_par`=1. State is IDLE, shift register = 0, counter = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `byte_ready` to any output except through state.
- Latency: `fifo_pop` at cycle t → data captured at the end of t+1 → first `byte_valid` at t+2.
- Throughput with `byte_ready` held at 1: 16 bytes in cycles t+2..t+17, `block_done` at t+18, next `fifo_pop` at t+19 at the earliest. That is 19 cycles per block.
- The counter wraps 15→0 only when leaving SEND; it is reloaded in WAIT.

## Configuration
- `BLOCK_SER_PARITY_EN` defined:
  - Adds output port `byte_par` = ~^`byte_out`, registered alongside `byte_out`.
  - Reset value 1, the odd parity of 8'h00.
- `BLOCK_SER_PARITY_EN` not defined:
  - Port is absent.
  - All other behaviour is identical.

## Test plan
- Reset with FIFO empty, `en`=1, 10 cycles → `fifo_pop` stays 0, all outputs at reset values.
- One block 128'h000102030405060708090A0B0C0D0E0F, `byte_ready`=1 → `fifo_pop` once; bytes 00..0F on consecutive cycles with `byte_first` on 00; `block_done` one cycle after 0F; the 19-cycle schedule is met.
- Same block, `byte_ready` toggled 1,0,0,1… → each byte is held while ready is low, no byte is skipped or duplicated, order is 00..0F.
- Two blocks queued, 128'hFF…FF then 128'hA5…A5 → 32 bytes; the second block's `fifo_pop` comes exactly 1 cycle after the first `block_done`; two `byte_first` pulses.
- `en` dropped after byte 5 with 1 block still queued → current block finishes through 0F and no further pop occurs until `en` returns high.
- `rst_n` pulsed low asynchronously after byte 7 → outputs reach reset values immediately. After release, the next queued block starts from byte 0. With `BLOCK_SER_PARITY_EN`, check `byte_par`=0 for 8'h01 and 1 for 8'h03.

Source files
------------

// File: rtl/block_serializer.sv
// block_serializer
//   Pops one 128-bit block from the plaintext FIFO and streams it as 16 bytes
//   over a valid/ready byte channel, most significant byte first. byte_first
//   marks byte 0 of each block; block_done pulses for one cycle after the
//   last byte is accepted.
//
//   Optional feature macro: BLOCK_SER_PARITY_EN adds byte_par (odd parity
//   of byte_out).
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   permission to start a new block
//   fifo_data   in   128-bit FIFO read data, valid the cycle after fifo_pop
//   fifo_empty  in   FIFO empty flag
//   fifo_pop    out  single-cycle FIFO read request
//   byte_out    out  current byte
//   byte_valid  out  byte_out is valid
//   byte_ready  in   sink accepts the byte when byte_valid && byte_ready
//   byte_first  out  high with byte 0 of each block
//   block_done  out  one-cycle pulse after byte 15 is accepted
//   byte_par    out  odd parity of byte_out (BLOCK_SER_PARITY_EN only)
module block_serializer #(
  parameter int unsigned BYTES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [127:0] fifo_data,
  input  logic         fifo_empty,
  output logic         fifo_pop,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         byte_first,
  output logic         block_done
`ifdef BLOCK_SER_PARITY_EN
  ,
  output logic         byte_par
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] shreg_q, shreg_d;
  logic [3:0]   cnt_q,   cnt_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && !fifo_empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        shreg_d = fifo_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (byte_ready) begin
          shreg_d = {shreg_q[119:0], 8'h00};
          // 4-bit counter wraps 15->0 on the final handshake
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'(BYTES - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; byte_ready reaches outputs only
  // through state. fifo_pop is qualified by rst_n so a queued block is not
  // requested while reset is held.
  always_comb begin
    fifo_pop   = rst_n && (state_q == S_IDLE) && en && !fifo_empty;
    byte_valid = (state_q == S_SEND);
    byte_out   = shreg_q[127:120];
    byte_first = (state_q == S_SEND) && (cnt_q == 4'd0);
    block_done = (state_q == S_DONE);
  end

`ifdef BLOCK_SER_PARITY_EN
  always_comb begin
    byte_par = ~^shreg_q[127:120];
  end
`endif

endmodule

// File: tb/tb_block_serializer.sv
module tb_block_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [127:0] fifo_data;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_first;
  logic         block_done;
`ifdef BLOCK_SER_PARITY_EN
  logic         byte_par;
`endif

  always #5 clk = ~clk;

  block_serializer #(.BYTES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_first (byte_first),
    .block_done (block_done)
`ifdef BLOCK_SER_PARITY_EN
    ,
    .byte_par   (byte_par)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents, expected byte stream and block timing
  logic [127:0] fq[$];
  logic [7:0]   eb[$];
  bit           inflight    = 1'b0;
  int           cyc         = 0;
  int           pop_cyc     = 0;
  int           last_hs_cyc = -10;
  int           bytes_left  = 0;
  int           first_cnt   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [127:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop"},   128'(fifo_pop),   128'd0);
    check({tag, "_valid"}, 128'(byte_valid), 128'd0);
    check({tag, "_byte"},  128'(byte_out),   128'd0);
    check({tag, "_first"}, 128'(byte_first), 128'd0);
    check({tag, "_done"},  128'(block_done), 128'd0);
`ifdef BLOCK_SER_PARITY_EN
    check({tag, "_par"},   128'(byte_par),   128'd1);
`endif
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick(input logic rdy);
    logic exp_pop, exp_valid, exp_done, pop_seen;
    byte_ready = rdy;
    #1;
    exp_pop   = en && !fifo_empty && !inflight;
    exp_valid = inflight && (cyc >= pop_cyc + 2) && (bytes_left > 0);
    exp_done  = inflight && (bytes_left == 0) && (cyc == last_hs_cyc + 1);
    check("fifo_pop",   128'(fifo_pop),   128'(exp_pop));
    check("byte_valid", 128'(byte_valid), 128'(exp_valid));
    check("block_done", 128'(block_done), 128'(exp_done));
    if (exp_valid && eb.size() > 0) begin
      check("byte_out",   128'(byte_out),   128'(eb[0]));
      check("byte_first", 128'(byte_first), 128'(bytes_left == 16));
`ifdef BLOCK_SER_PARITY_EN
      check("byte_par",   128'(byte_par),   128'(~^eb[0]));
`endif
    end else begin
      check("byte_first_idle", 128'(byte_first), 128'd0);
    end
    if (byte_first === 1'b1) first_cnt++;
    pop_seen = fifo_pop;
    if (exp_valid && rdy) begin
      if (eb.size() > 0) void'(eb.pop_front());
      bytes_left--;
      last_hs_cyc = cyc;
    end
    if (exp_done) inflight = 1'b0;
    if (exp_pop) begin
      inflight   = 1'b1;
      pop_cyc    = cyc;
      bytes_left = 16;
    end
    @(posedge clk);
    #1;
    if (pop_seen === 1'b1 && fq.size() > 0) begin
      fifo_data = fq.pop_front();
      if (exp_pop)
        for (int k = 0; k < 16; k++) eb.push_back(fifo_data[127 - 8*k -: 8]);
    end
    fifo_empty = (fq.size() == 0);
    cyc++;
    @(negedge clk);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run(input int n, input int mode);
    logic r;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((i % 4) == 0) || ((i % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tick(r);
    end
  endtask

  task automatic run_until_left(input int left, input int maxc);
    int i = 0;
    while (!(inflight && bytes_left == left) && i < maxc) begin
      tick(1'b1);
      i++;
    end
    check("reach_byte_timeout", 128'(i < maxc), 128'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    byte_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;

    // Reset with empty FIFO and en high
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    run(10, 0);
    check_reset_outputs("rst_idle");

    // Single block, ready held high: 19-cycle schedule
    push(128'h000102030405060708090A0B0C0D0E0F);
    run(22, 0);

    // Same block with ready toggled 1,0,0,1
    push(128'h000102030405060708090A0B0C0D0E0F);
    run(70, 1);

    // Two back-to-back blocks
    first_cnt = 0;
    push({16{8'hFF}});
    push({16{8'hA5}});
    run(42, 0);
    check("first_pulses", 128'(first_cnt), 128'd2);

    // en dropped after byte 5 with one block still queued
    push({$urandom, $urandom, $urandom, $urandom});
    push({$urandom, $urandom, $urandom, $urandom});
    run_until_left(10, 20);
    en = 1'b0;
    run(40, 0);
    check("en_low_no_pop", 128'(fq.size()), 128'd1);
    en = 1'b1;
    run(25, 0);
    check("en_high_drained", 128'(fq.size()), 128'd0);

    // Random blocks, random ready and en
    for (int b = 0; b < 4; b++) push({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 200; i++) begin
      en = ($urandom_range(0, 3) != 0);
      tick(1'($urandom_range(0, 1)));
    end
    en = 1'b1;
    run(80, 0);
    check("random_drained", 128'(fq.size()), 128'd0);

    // Asynchronous reset after byte 7; the next queued block restarts cleanly
    push({$urandom, $urandom, $urandom, $urandom});
    push(128'h01035A7F80FF00001122334455667788);
    run_until_left(8, 30);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    inflight   = 1'b0;
    bytes_left = 0;
    eb.delete();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    run(25, 0);
    check("after_rst_drained", 128'(fq.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
